// File: rtl/signed_burst_accumulator_pkg.sv
// Shared definitions for the signed burst accumulator slice.
//   - FSM state codes (IDLE, ACC, DONE) as 2-bit constants
//   - Saturation limits for the 8-bit signed result
//   - sat_limit(): picks the clamp value from the sign of the incoming operand
package signed_burst_accumulator_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic signed [7:0] SAT_MAX = 8'sh7F;
  localparam logic signed [7:0] SAT_MIN = 8'sh80;

  // acc + operand can only overflow when both have the same sign, so the
  // operand sign alone tells which rail the true result ran past.
  function automatic logic [7:0] sat_limit(input logic operand_neg);
    return operand_neg ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/add8_signed_core.sv
// Purely combinational 8-bit signed ripple-carry adder.
// Ports:
//   a, b  : 8-bit two's-complement operands
//   cin   : carry in
//   sum   : a + b + cin, low 8 bits
//   cout  : carry out of bit 7
//   v     : signed overflow (carry into bit 7 XOR carry out of bit 7)
module add8_signed_core (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       v
);

  logic [8:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout = carry[8];
  assign v    = carry[7] ^ carry[8];

endmodule

// File: rtl/signed_burst_accumulator.sv
// Burst accumulator: collects N signed 8-bit operands over a valid/ready
// handshake, sums them through add8_signed_core, and offers one result word
// plus a sticky overflow flag on an output handshake.
// Parameters:
//   N   : operands per burst (1..255)
//   SAT : 1 = clamp to +127/-128 on overflow, 0 = two's-complement wrap
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begins a burst; only honoured in IDLE
//   in_valid/in_data/in_ready : operand handshake (in_ready high in ACC)
//   out_valid/out_sum/out_ovf/out_ready : result handshake (valid in DONE)
//   busy            : high in ACC or DONE
//   beat_cnt        : operands accepted in the current burst
module signed_burst_accumulator
  import signed_burst_accumulator_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned SAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_ovf,
  output logic       busy,
  output logic [7:0] beat_cnt
);

  localparam logic [7:0] LAST_BEAT = 8'(N - 1);

  logic [1:0] state;
  logic [7:0] acc;
  logic       ovf;

  logic [7:0] add_sum;
  logic       add_cout;
  logic       add_v;
  logic [7:0] acc_next;

  add8_signed_core u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .v    (add_v)
  );

  always_comb begin
    acc_next = add_sum;
    if (add_v && (SAT != 0)) begin
      acc_next = sat_limit(in_data[7]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      ovf      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            acc      <= '0;
            ovf      <= 1'b0;
            beat_cnt <= '0;
          end
        end
        ACC: begin
          // in_ready is exactly (state == ACC), so in_valid alone marks a beat.
          if (in_valid) begin
            acc      <= acc_next;
            ovf      <= ovf | add_v;
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below is a register or a pure state decode: acc and ovf only
  // change in IDLE/ACC, so out_sum/out_ovf are stable throughout DONE.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACC) || (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  logic unused_cout;
  assign unused_cout = add_cout;

endmodule

// File: tb/tb_signed_burst_accumulator.sv
module tb_signed_burst_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // index 0: N=4 SAT=1, index 1: N=4 SAT=0, index 2: N=2 SAT=1
  logic       start_s     [3];
  logic       in_valid_s  [3];
  logic [7:0] in_data_s   [3];
  logic       out_ready_s [3];
  logic       in_ready_s  [3];
  logic       out_valid_s [3];
  logic [7:0] out_sum_s   [3];
  logic       out_ovf_s   [3];
  logic       busy_s      [3];
  logic [7:0] beat_cnt_s  [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  signed_burst_accumulator #(.N(4), .SAT(1)) u_sat4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_data(in_data_s[0]), .in_ready(in_ready_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .out_sum(out_sum_s[0]), .out_ovf(out_ovf_s[0]),
    .busy(busy_s[0]), .beat_cnt(beat_cnt_s[0])
  );

  signed_burst_accumulator #(.N(4), .SAT(0)) u_wrap4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_data(in_data_s[1]), .in_ready(in_ready_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .out_sum(out_sum_s[1]), .out_ovf(out_ovf_s[1]),
    .busy(busy_s[1]), .beat_cnt(beat_cnt_s[1])
  );

  signed_burst_accumulator #(.N(2), .SAT(1)) u_sat2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_data(in_data_s[2]), .in_ready(in_ready_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .out_sum(out_sum_s[2]), .out_ovf(out_ovf_s[2]),
    .busy(busy_s[2]), .beat_cnt(beat_cnt_s[2])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int sel);
    start_s[sel] = 1'b1;
    tick();
    start_s[sel] = 1'b0;
  endtask

  // Operands packed low byte first; in_valid held high for n consecutive beats.
  task automatic feed(input int sel, input logic [31:0] ops, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid_s[sel] = 1'b1;
      in_data_s[sel]  = ops[8*i +: 8];
      tick();
    end
    in_valid_s[sel] = 1'b0;
  endtask

  task automatic retire(input int sel);
    out_ready_s[sel] = 1'b1;
    tick();
    out_ready_s[sel] = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({in_ready_s[s], out_valid_s[s], out_ovf_s[s], busy_s[s]} !== 4'b0000 ||
          out_sum_s[s] !== 8'h00 || beat_cnt_s[s] !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d got rdy=%b vld=%b ovf=%b busy=%b sum=%h cnt=%h exp all 0",
                 s, in_ready_s[s], out_valid_s[s], out_ovf_s[s], busy_s[s], out_sum_s[s], beat_cnt_s[s]);
      end
    end
    #5 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    start_burst(0);
    checks++;
    if (in_ready_s[0] !== 1'b1 || busy_s[0] !== 1'b1 || beat_cnt_s[0] !== 8'd0) begin
      failures++;
      $display("FAIL basic_acc_entry got rdy=%b busy=%b cnt=%0d exp 1 1 0", in_ready_s[0], busy_s[0], beat_cnt_s[0]);
    end
    feed(0, 32'h00FB140A, 3);                  // 10, 20, -5
    checks++;
    if (out_valid_s[0] !== 1'b0 || beat_cnt_s[0] !== 8'd3) begin
      failures++;
      $display("FAIL basic_three_beats got vld=%b cnt=%0d exp 0 3", out_valid_s[0], beat_cnt_s[0]);
    end
    feed(0, 32'h00000007, 1);                  // 7
    checks++;
    if (out_valid_s[0] !== 1'b1 || out_sum_s[0] !== 8'd32 || out_ovf_s[0] !== 1'b0 ||
        beat_cnt_s[0] !== 8'd4 || in_ready_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got vld=%b sum=%0d ovf=%b cnt=%0d rdy=%b exp 1 32 0 4 0",
               out_valid_s[0], out_sum_s[0], out_ovf_s[0], beat_cnt_s[0], in_ready_s[0]);
    end
    retire(0);
    checks++;
    if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_retire got vld=%b busy=%b exp 0 0", out_valid_s[0], busy_s[0]);
    end
  endtask

  task automatic test_saturate;
    start_burst(0);
    feed(0, 32'h01E23264, 4);                  // 100, 50, -30, 1
    checks++;
    if (out_valid_s[0] !== 1'b1 || out_sum_s[0] !== 8'd98 || out_ovf_s[0] !== 1'b1) begin
      failures++;
      $display("FAIL saturate_result got vld=%b sum=%h ovf=%b exp 1 62 1", out_valid_s[0], out_sum_s[0], out_ovf_s[0]);
    end
    retire(0);
  endtask

  task automatic test_wrap;
    start_burst(1);
    feed(1, 32'h01E23264, 4);                  // -106, 120, 121
    checks++;
    if (out_valid_s[1] !== 1'b1 || out_sum_s[1] !== 8'd121 || out_ovf_s[1] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_result got vld=%b sum=%h ovf=%b exp 1 79 1", out_valid_s[1], out_sum_s[1], out_ovf_s[1]);
    end
    retire(1);
  endtask

  task automatic test_hold;
    start_burst(2);
    feed(2, 32'h00009C9C, 2);                  // -100, -100
    checks++;
    if (out_valid_s[2] !== 1'b1 || out_sum_s[2] !== 8'h80 || out_ovf_s[2] !== 1'b1) begin
      failures++;
      $display("FAIL hold_result got vld=%b sum=%h ovf=%b exp 1 80 1", out_valid_s[2], out_sum_s[2], out_ovf_s[2]);
    end
    for (int c = 0; c < 5; c++) begin
      start_s[2] = (c == 2);                   // start while in DONE must be ignored
      tick();
      checks++;
      if (out_valid_s[2] !== 1'b1 || out_sum_s[2] !== 8'h80 || out_ovf_s[2] !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable cycle=%0d got vld=%b sum=%h ovf=%b exp 1 80 1",
                 c, out_valid_s[2], out_sum_s[2], out_ovf_s[2]);
      end
    end
    start_s[2] = 1'b1;
    out_ready_s[2] = 1'b1;
    tick();
    start_s[2] = 1'b0;
    out_ready_s[2] = 1'b0;
    checks++;
    if (out_valid_s[2] !== 1'b0 || busy_s[2] !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got vld=%b busy=%b exp 0 0", out_valid_s[2], busy_s[2]);
    end
    tick();
    checks++;
    if (busy_s[2] !== 1'b0 || in_ready_s[2] !== 1'b0) begin
      failures++;
      $display("FAIL hold_start_not_queued got busy=%b rdy=%b exp 0 0", busy_s[2], in_ready_s[2]);
    end
  endtask

  task automatic test_gaps;
    logic [31:0] ops;
    int          k;
    logic [7:0]  exp_cnt;
    // in_valid in IDLE is not a beat
    in_valid_s[0] = 1'b1;
    in_data_s[0]  = 8'h11;
    tick();
    in_valid_s[0] = 1'b0;
    checks++;
    if (in_ready_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || beat_cnt_s[0] !== 8'd4) begin
      failures++;
      $display("FAIL idle_ignores_valid got rdy=%b busy=%b cnt=%0d exp 0 0 4", in_ready_s[0], busy_s[0], beat_cnt_s[0]);
    end
    start_burst(0);
    ops = 32'h07FB140A;                        // 10, 20, -5, 7
    k = 0;
    exp_cnt = 8'd0;
    for (int c = 1; c <= 9; c++) begin
      in_valid_s[0] = (c == 1 || c == 4 || c == 5 || c == 9);
      in_data_s[0]  = in_valid_s[0] ? ops[8*k +: 8] : 8'h55;
      start_s[0]    = (c == 2);
      if (in_valid_s[0]) begin
        k++;
        exp_cnt = exp_cnt + 8'd1;
      end
      tick();
      checks++;
      if (beat_cnt_s[0] !== exp_cnt || busy_s[0] !== 1'b1 || out_valid_s[0] !== (c == 9)) begin
        failures++;
        $display("FAIL gaps_cycle c=%0d got cnt=%0d busy=%b vld=%b exp %0d 1 %b",
                 c, beat_cnt_s[0], busy_s[0], out_valid_s[0], exp_cnt, (c == 9));
      end
    end
    in_valid_s[0] = 1'b0;
    start_s[0] = 1'b0;
    checks++;
    if (out_sum_s[0] !== 8'd32 || out_ovf_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL gaps_result got sum=%0d ovf=%b exp 32 0", out_sum_s[0], out_ovf_s[0]);
    end
    retire(0);
  endtask

  task automatic test_async_reset;
    start_burst(0);
    feed(0, 32'h0000140A, 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_s[0], out_valid_s[0], out_ovf_s[0], busy_s[0]} !== 4'b0000 ||
        out_sum_s[0] !== 8'h00 || beat_cnt_s[0] !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got rdy=%b vld=%b ovf=%b busy=%b sum=%h cnt=%h exp all 0",
               in_ready_s[0], out_valid_s[0], out_ovf_s[0], busy_s[0], out_sum_s[0], beat_cnt_s[0]);
    end
    #1 rst_n = 1'b1;
    tick();
    start_burst(0);
    feed(0, 32'h01010101, 4);
    checks++;
    if (out_valid_s[0] !== 1'b1 || out_sum_s[0] !== 8'd4 || out_ovf_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_burst got vld=%b sum=%0d ovf=%b exp 1 4 0", out_valid_s[0], out_sum_s[0], out_ovf_s[0]);
    end
    retire(0);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      start_s[s]     = 1'b0;
      in_valid_s[s]  = 1'b0;
      in_data_s[s]   = 8'h00;
      out_ready_s[s] = 1'b0;
    end
    test_reset();
    test_basic();
    test_saturate();
    test_wrap();
    test_hold();
    test_gaps();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
